// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: monitors a multiplexed active-low 7-segment bus.
// Each digit slot is debounced and decoded back to BCD. A complete
// multi-digit word is published with a one-cycle frame_valid strobe.
// A stale flag reports when no frame has completed for too long.
module seg7_scan_capture #(
  parameter int digits         = 4,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_n,
  input  logic [digits-1:0]     an_n,
  output logic [4*digits-1:0]   bcds,
  output logic [digits-1:0]     digit_err,
  output logic                  frame_valid,
  output logic                  stale
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int SW = (digits > 1) ? $clog2(digits) : 1;

  localparam logic [1:0] ST_WAIT   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_HELD   = 2'd2;

  logic [6:0]          s1_seg, s2_seg;
  logic [digits-1:0]   s1_an, s2_an;
  logic [1:0]          state, state_next;
  logic [CW-1:0]       cnt, cnt_next, cnt_inc;
  logic [TW-1:0]       tcnt;
  logic [4*digits-1:0] shadow;
  logic [digits-1:0]   shadow_err, seen, cap_mask, low_mask;
  logic [SW-1:0]       slot;
  logic                sel, eq, hit, cap, publish;
  logic [4:0]          dec;

  // Map an active-low abcdefg pattern to {err, code}.
  function automatic logic [4:0] decode(input logic [6:0] pat_n);
    logic [6:0] lit;
    lit = ~pat_n;
    case (lit)
      7'b1111110: decode = 5'h00;
      7'b0110000: decode = 5'h01;
      7'b1101101: decode = 5'h02;
      7'b1111001: decode = 5'h03;
      7'b0110011: decode = 5'h04;
      7'b1011011: decode = 5'h05;
      7'b1011111: decode = 5'h06;
      7'b1110000: decode = 5'h07;
      7'b1111111: decode = 5'h08;
      7'b1111011: decode = 5'h09;
      7'b0000000: decode = 5'h0F;
      default:    decode = 5'h1E;
    endcase
  endfunction

  // Two-flop synchronizer on the whole bus; idle bus is all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_seg <= '1;
      s2_seg <= '1;
      s1_an  <= '1;
      s2_an  <= '1;
    end else begin
      s1_seg <= seg_n;
      s2_seg <= s1_seg;
      s1_an  <= an_n;
      s2_an  <= s1_an;
    end
  end

  // Slot selection: exactly one enable low; also stability compare and decode.
  always_comb begin
    low_mask = ~s2_an;
    sel      = (low_mask != '0) && ((low_mask & (low_mask - 1'b1)) == '0);
    slot     = '0;
    for (int k = 0; k < digits; k++) begin
      if (low_mask[k]) slot = SW'(k);
    end
    eq      = (s1_seg == s2_seg) && (s1_an == s2_an);
    cnt_inc = cnt + 1'b1;
    hit     = (cnt_inc == CW'(STABLE_CYCLES));
    dec     = decode(s2_seg);
  end

  // Debounce FSM: WAIT (no slot), SETTLE (counting), HELD (captured, idle).
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    cap        = 1'b0;
    case (state)
      ST_HELD: begin
        if (!eq || !sel) begin
          cnt_next   = '0;
          state_next = sel ? ST_SETTLE : ST_WAIT;
        end
      end
      default: begin
        if (!sel) begin
          cnt_next   = '0;
          state_next = ST_WAIT;
        end else if (!eq) begin
          cnt_next   = '0;
          state_next = ST_SETTLE;
        end else if (hit) begin
          cnt_next   = '0;
          cap        = 1'b1;
          state_next = ST_HELD;
        end else begin
          cnt_next   = cnt_inc;
          state_next = ST_SETTLE;
        end
      end
    endcase
    cap_mask = cap ? (digits'(1) << slot) : '0;
    publish  = &seen;
  end

  // FSM state and stability counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_WAIT;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Shadow slots and seen mask; a full mask publishes on the following edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow     <= '1;
      shadow_err <= '0;
      seen       <= '0;
    end else begin
      if (cap) begin
        shadow[4*slot +: 4] <= dec[3:0];
        shadow_err[slot]    <= dec[4];
      end
      seen <= publish ? cap_mask : (seen | cap_mask);
    end
  end

  // Published word, frame strobe and staleness timeout (publish wins).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcds        <= '1;
      digit_err   <= '0;
      frame_valid <= 1'b0;
      stale       <= 1'b1;
      tcnt        <= '0;
    end else begin
      frame_valid <= publish;
      if (publish) begin
        bcds      <= shadow;
        digit_err <= shadow_err;
        stale     <= 1'b0;
        tcnt      <= '0;
      end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
        stale <= 1'b1;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

endmodule
